serial_add: RTL and testbench



---
 rtl/add_pkg.sv | 12 +
 rtl/fadd_hh.sv | 20 ++
 rtl/half_add.sv | 12 +
 rtl/serial_add.sv | 95 +++++++++
 tb/tb_serial_add.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int ADD_W = 8;

endpackage

// File: rtl/fadd_hh.sv
// Combinational full adder made from two half adders and an OR of their carries.
module fadd_hh (
  output logic S,
  output logic Cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  logic s0;
  logic c0;
  logic c1;

  half_add u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_add u_ha1 (.a(s0), .b(cin), .s(S),  .c(c1));

  // Both half-adder carries can never be high together, so OR equals the true carry.
  assign Cout = c0 | c1;

endmodule

// File: rtl/half_add.sv
// Half adder cell: the building block of the serial adder's single full-adder stage.
module half_add (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add.sv
// Bit-serial ripple adder: one full-adder cell processes the operands LSB-first,
// one bit per clock, and publishes {cout,sum} N cycles after the accepting edge.
module serial_add
  import add_pkg::*;
#(
  parameter int N = ADD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  ra;
  logic [N-1:0]  rb;
  // Only the upper N-1 result bits need storage; the newest bit arrives from the adder.
  logic [N-2:0]  rs;
  logic [N-1:0]  rs_next;
  logic          c;
  logic          c_next;
  logic          s;
  logic [CW-1:0] cnt;
  logic          load;
  logic          last_bit;

  fadd_hh u_fa (
    .S   (s),
    .Cout(c_next),
    .a   (ra[0]),
    .b   (rb[0]),
    .cin (c)
  );

  assign rs_next  = {s, rs};
  assign load     = ((state == IDLE) || (state == DONE)) && start;
  assign last_bit = (state == RUN) && (cnt == LAST);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: next-state is defaulted first so no path leaves it unassigned and a latch cannot form.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: operand/result shift registers are reset too; they are small and it keeps sim free of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra   <= '0;
      rb   <= '0;
      rs   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (load) begin
      ra  <= a;
      rb  <= b;
      c   <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      rs  <= rs_next[N-1:1];
      c   <= c_next;
      cnt <= cnt + 1'b1;
      if (last_bit) begin
        sum  <= rs_next;
        cout <= c_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_add.sv
// Scoreboard bench for serial_add at N=8 and N=2: drivers queue {cout,sum}=a+b with the
// cycle done must appear on; a negedge monitor checks busy/done/result/hold behaviour.
module tb_serial_add;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start8 = 1'b0;
  logic       start2 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       busy8, done8, cout8;
  logic       busy2, done2, cout2;
  logic [7:0] sum8;
  logic [1:0] sum2;

  always #5 clk = ~clk;

  serial_add #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  typedef struct {
    int         inst;
    logic [8:0] res;
    int         done_cyc;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [8:0] last [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Issue one addition on instance i (0: N=8, 1: N=2); returns at accepting edge + 1.
  task automatic go(input int i, input int av, input int bv);
    exp_t e;
    int   w;
    w = (i == 0) ? 8 : 2;
    if (i == 0) begin
      a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1;
    end else begin
      a2 = av[1:0]; b2 = bv[1:0]; start2 = 1'b1;
    end
    @(posedge clk);
    #1;
    start8 = 1'b0;
    start2 = 1'b0;
    e.inst     = i;
    e.res      = 9'((av % (1 << w)) + (bv % (1 << w)));
    e.done_cyc = cyc + w;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && q.size() > 0; k++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      check("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last[0] = '0;
      last[1] = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic       d;
        logic       bz;
        logic [8:0] r;
        bit         has;
        int         dc;
        d   = (i == 0) ? done8 : done2;
        bz  = (i == 0) ? busy8 : busy2;
        r   = (i == 0) ? {cout8, sum8} : {6'b0, cout2, sum2};
        has = (q.size() > 0) && (q[0].inst == i);
        dc  = has ? q[0].done_cyc : 0;
        if (bz && d) check($sformatf("busy_and_done_%0d", i), 1, 0);
        check($sformatf("busy_%0d", i), bz, (has && cyc < dc));
        if (has && cyc == dc) begin
          check($sformatf("done_%0d", i), d, 1);
          check($sformatf("result_%0d", i), r, q[0].res);
          last[i] = r;
          void'(q.pop_front());
        end else begin
          check($sformatf("no_done_%0d", i), d, 0);
          check($sformatf("hold_%0d", i), r, last[i]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset_busy8", busy8, 0);
    check("reset_done8", done8, 0);
    check("reset_res8",  {cout8, sum8}, 0);
    check("reset_res2",  {cout2, sum2}, 0);
    #9 rst_n = 1'b1;

    // Carry ripple through all bits.
    go(0, 'hFF, 'h01);
    wait_idle();

    // No-carry, then zero; result must hold in between.
    go(0, 'hA5, 'h5A);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    go(0, 'h00, 'h00);
    wait_idle();

    // A start during RUN must be ignored.
    go(0, 'h10, 'h20);
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    wait_idle();

    // Back-to-back: second start held during the DONE cycle.
    go(0, 'h80, 'h80);
    repeat (8) @(posedge clk);
    #1;
    go(0, 'h01, 'h02);
    wait_idle();

    // Asynchronous reset mid-run aborts without a done pulse.
    go(0, 'hFF, 'hFF);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy8", busy8, 0);
    check("midrst_done8", done8, 0);
    check("midrst_sum8",  sum8, 0);
    check("midrst_cout8", cout8, 0);
    q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    go(0, 'h3C, 'hC4);
    wait_idle();

    // Randomised operands with random idle gaps.
    for (int n = 0; n < 20; n++) begin
      go(0, int'($urandom_range(255)), int'($urandom_range(255)));
      wait_idle();
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end

    // Exhaustive at N=2.
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        go(1, x, y);
        wait_idle();
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
